// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: state encoding seen on oState,
// default timing parameters and a counter-width helper.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  localparam int TICK_DIV_DEF = 500_000;  // 10 ms at 50 MHz
  localparam int DEB_CYC_DEF  = 500_000;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// One pushbutton path: 2-FF synchroniser, stability counter, and a one-cycle
// registered pulse on the accepted press (1->0) edge. Releases produce nothing.
module btn_debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic Clk,
  input  logic Rst,
  input  logic iBtn_n,
  output logic oPress
);

  localparam int            CW    = cnt_width(DEB_CYC);
  localparam logic [CW-1:0] LP_TC = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] LP_ONE = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic          r_deb_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_deb   <= 1'b1;
      r_deb_d <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= iBtn_n;
      r_sync2 <= r_sync1;
      // any return to the accepted level restarts the stability window
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_TC) begin
        r_cnt <= '0;
        r_deb <= r_sync2;
      end else begin
        r_cnt <= r_cnt + LP_ONE;
      end
      r_deb_d <= r_deb;
      r_press <= r_deb_d & ~r_deb;
    end
  end

  assign oPress = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounced buttons drive the run/pause/lap/clear FSM,
// a 10 ms prescaler issues count-enable ticks to the time-counter datapath.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | stopped at zero, prescaler held at 0
//   ST_RUN   | counting, display live
//   ST_PAUSE | counting halted, prescaler phase retained
//   ST_LAP   | counting continues, display frozen on lap value
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DEB_CYC  = DEB_CYC_DEF
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       fStart,
  input  logic       fStop,
  output logic       oCntEn,
  output logic       oCntClr,
  output logic       oFreeze,
  output logic [1:0] oState
);

  localparam int            PW      = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] LP_WRAP = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] LP_ONE  = PW'(1);

  logic          w_start;
  logic          w_stop;
  logic          w_running;
  logic          w_wrap;
  logic          w_clr_nxt;
  state_t        w_state_nxt;
  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic          r_cnt_en;
  logic          r_cnt_clr;
  logic          r_freeze;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_start (
    .Clk    (Clk),
    .Rst    (Rst),
    .iBtn_n (fStart),
    .oPress (w_start)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_stop (
    .Clk    (Clk),
    .Rst    (Rst),
    .iBtn_n (fStop),
    .oPress (w_stop)
  );

  assign w_running = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign w_wrap    = w_running && (r_presc == LP_WRAP);

  // stop has priority; a start arriving in the same cycle is dropped
  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_stop && w_start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_stop)       w_state_nxt = ST_LAP;
        else if (w_start) w_state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (w_stop) begin
          w_state_nxt = ST_IDLE;
          w_clr_nxt   = 1'b1;
        end else if (w_start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LAP: begin
        if (w_stop)       w_state_nxt = ST_RUN;
        else if (w_start) w_state_nxt = ST_PAUSE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_cnt_en  <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_freeze  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // PAUSE falls through both branches, so the phase is kept for resume
      if (r_state == ST_IDLE) begin
        r_presc <= '0;
      end else if (w_running) begin
        r_presc <= w_wrap ? '0 : (r_presc + LP_ONE);
      end
      r_cnt_en  <= w_wrap;
      r_cnt_clr <= w_clr_nxt;
      r_freeze  <= (w_state_nxt == ST_LAP);
    end
  end

  assign oCntEn  = r_cnt_en;
  assign oCntClr = r_cnt_clr;
  assign oFreeze = r_freeze;
  assign oState  = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a cycle-level reference model predicts tick,
// clear and state/freeze events into a queue; a monitor pops them as the DUT shows them.
module tb_stopwatch_ctrl;

  localparam int DEB    = 4;
  localparam int TDIV   = 10;
  localparam int HLEN   = DEB + 2;
  localparam int K_TICK = 0;
  localparam int K_CLR  = 1;
  localparam int K_ST   = 2;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  logic       Clk    = 1'b0;
  logic       Rst    = 1'b0;
  logic       fStart = 1'b1;
  logic       fStop  = 1'b1;
  logic       oCntEn;
  logic       oCntClr;
  logic       oFreeze;
  logic [1:0] oState;

  stopwatch_ctrl #(.TICK_DIV(TDIV), .DEB_CYC(DEB)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .fStart  (fStart),
    .fStop   (fStop),
    .oCntEn  (oCntEn),
    .oCntClr (oCntClr),
    .oFreeze (oFreeze),
    .oState  (oState)
  );

  always #10 Clk = ~Clk;

  int  n_chk  = 0;
  int  n_pass = 0;
  int  cyc    = 0;
  ev_t exq[$];

  // reference model: states 0 IDLE, 1 RUN, 2 PAUSE, 3 LAP
  int nxt_start[4] = '{1, 2, 1, 2};
  int nxt_stop[4]  = '{0, 3, 0, 1};
  int m_state;
  int m_phase;
  bit m_deb[2];
  bit m_p1[2];
  bit m_p2[2];
  bit m_hist[2][HLEN];

  task automatic push_ev(input int kind, input int val);
    ev_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = val;
    exq.push_back(e);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_phase = 0;
    for (int b = 0; b < 2; b++) begin
      m_deb[b] = 1'b1;
      m_p1[b]  = 1'b0;
      m_p2[b]  = 1'b0;
      for (int i = 0; i < HLEN; i++) m_hist[b][i] = 1'b1;
    end
    exq.delete();
  endtask

  // a level is accepted once the samples taken DEB+1..2 edges ago all disagree with it;
  // the press takes effect on the FSM two edges after acceptance
  task automatic model_step(input bit raw_start, input bit raw_stop);
    bit raw[2];
    bit app[2];
    bit diff;
    bit fall;
    int old_st;
    int nx;
    raw[0] = raw_start;
    raw[1] = raw_stop;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < HLEN - 1; i++) m_hist[b][i] = m_hist[b][i+1];
      m_hist[b][HLEN-1] = raw[b];
      diff = 1'b1;
      for (int i = 0; i < DEB; i++) if (m_hist[b][i] == m_deb[b]) diff = 1'b0;
      fall = diff && m_deb[b];
      if (diff) m_deb[b] = ~m_deb[b];
      app[b]  = m_p2[b];
      m_p2[b] = m_p1[b];
      m_p1[b] = fall;
    end
    old_st = m_state;
    if (old_st == 1 || old_st == 3) begin
      m_phase++;
      if (m_phase == TDIV) begin
        push_ev(K_TICK, 0);
        m_phase = 0;
      end
    end else if (old_st == 0) begin
      m_phase = 0;
    end
    nx = old_st;
    if (app[1])      nx = nxt_stop[old_st];
    else if (app[0]) nx = nxt_start[old_st];
    if (old_st == 2 && app[1]) push_ev(K_CLR, 0);
    if (nx != old_st) push_ev(K_ST, nx + ((nx == 3) ? 4 : 0));
    m_state = nx;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge Clk);
      cyc++;
      if (!Rst) model_reset();
      else      model_step(fStart, fStop);
    end
  end

  task automatic take(input int kind, input int val);
    ev_t e;
    n_chk++;
    if (exq.size() == 0) begin
      $display("FAIL unexpected_event cyc=%0d actual kind=%0d val=%0d required=none", cyc, kind, val);
    end else begin
      e = exq.pop_front();
      if (e.cyc == cyc && e.kind == kind && e.val == val) n_pass++;
      else $display("FAIL event cyc=%0d actual kind=%0d val=%0d required cyc=%0d kind=%0d val=%0d",
                    cyc, kind, val, e.cyc, e.kind, e.val);
    end
  endtask

  initial begin
    logic [1:0] p_st;
    logic       p_frz;
    p_st  = 2'd0;
    p_frz = 1'b0;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        p_st  = oState;
        p_frz = oFreeze;
      end else begin
        while (exq.size() > 0 && exq[0].cyc < cyc) begin
          n_chk++;
          $display("FAIL missing_event cyc=%0d actual=none required kind=%0d val=%0d at cyc=%0d",
                   cyc, exq[0].kind, exq[0].val, exq[0].cyc);
          exq.delete(0);
        end
        if (oCntEn)  take(K_TICK, 0);
        if (oCntClr) take(K_CLR, 0);
        if (oState != p_st || oFreeze != p_frz) take(K_ST, {29'd0, oFreeze, oState});
        p_st  = oState;
        p_frz = oFreeze;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  // which: 0 start, 1 stop, 2 both in the same cycle
  task automatic btn(input int which, input int lo, input int hi);
    @(negedge Clk);
    if (which != 1) fStart = 1'b0;
    if (which != 0) fStop  = 1'b0;
    repeat (lo) @(negedge Clk);
    fStart = 1'b1;
    fStop  = 1'b1;
    repeat (hi) @(negedge Clk);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    #1;
    chk("reset_state",  int'(oState),  0);
    chk("reset_cnt_en", int'(oCntEn),  0);
    chk("reset_clr",    int'(oCntClr), 0);
    chk("reset_freeze", int'(oFreeze), 0);
    @(negedge Clk);
    Rst = 1'b1;
    repeat (100) @(negedge Clk);

    btn(0, 20, 20);
    repeat (100) @(negedge Clk);

    btn(0, 3, 20);
    @(negedge Clk) fStart = 1'b0;
    @(negedge Clk) fStart = 1'b1;
    @(negedge Clk) fStart = 1'b0;
    @(negedge Clk) fStart = 1'b1;
    @(negedge Clk) fStart = 1'b0;
    repeat (10) @(negedge Clk);
    fStart = 1'b1;
    repeat (23) @(negedge Clk);
    btn(0, 20, 50);

    btn(1, 20, 30);
    btn(1, 20, 30);

    btn(0, 20, 20);
    btn(1, 20, 20);
    btn(0, 20, 20);
    btn(2, 20, 20);
    btn(1, 20, 13);
    chk("pre_reset_state", int'(oState), 1);
    @(negedge Clk);
    #3 Rst = 1'b0;
    #1;
    chk("async_rst_state",  int'(oState),  0);
    chk("async_rst_cnt_en", int'(oCntEn),  0);
    chk("async_rst_clr",    int'(oCntClr), 0);
    chk("async_rst_freeze", int'(oFreeze), 0);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    repeat (10) @(negedge Clk);

    repeat (80) begin
      btn($urandom_range(0, 2), $urandom_range(1, 12), $urandom_range(1, 25));
    end

    fStart = 1'b1;
    fStop  = 1'b1;
    repeat (40) @(negedge Clk);
    #1;
    chk("leftover_events", exq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
